bus_decoder: RTL
================

# bus_decoder

Single-master to multi-slave bus decoder that sits directly upstream of the timer and the other memory-mapped peripherals. It takes one valid/ready request from the CPU data port, matches the address against per-slave base/mask windows and forwards the request to exactly one slave. It registers that slave's read data back to the master. Unmapped addresses and hung slaves terminate with an error response, so the core never stalls forever.

## Interface
Parameters:
- NSLV, 4, number of slave ports (1..8)
- SLV_BASE, {32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000}, packed 32·NSLV; slot i = bits [32i+31:32i]
- SLV_MASK, {4{32'hFFFF_F000}}, packed 32·NSLV address masks
- TIMEOUT, 16, maximum cycles a selected slave may take to assert ready (≥2)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous reset, active-high
- m_valid  in  1  master request
- m_ready  out  1  one-cycle completion pulse to master
- m_addr  in  32  request address
- m_wdata  in  32  write data
- m_wstrb  in  4  byte strobes; 0 = read
- m_rdata  out  32  response data, valid while m_ready=1
- s_valid  out  NSLV  per-slave request, one-hot or zero
- s_ready  in  NSLV  per-slave ready
- s_addr  out  32  shared; equals m_addr
- s_wdata  out  32  shared; equals m_wdata
- s_wstrb  out  4  shared; equals m_wstrb
- s_rdata  in  32·NSLV  packed slave read data, slot i = [32i+31:32i]
- bus_err  out  1  one-cycle pulse coincident with an error m_ready
- err_addr  out  32  address of most recent error, held until next error

## Operation
- Decode: slave i hits when (m_addr & SLV_MASK[i]) == SLV_BASE[i]. On multiple hits, the lowest index wins.
- FSM states are IDLE, WAIT, RESP and ERR. Reset enters IDLE.
- IDLE: with m_valid=1, register the winning index into sel, clear the timeout counter and go to WAIT. With no hit, go to ERR. With m_valid=0, stay in IDLE.
- WAIT: s_valid[sel]=1 and all other s_valid bits are 0. Transitions are evaluated in this priority order:
  - m_valid=0 (master abort): go to IDLE with no response.
  - s_ready[sel]=1: capture s_rdata slot sel into the rdata register, then go to RESP.
  - Counter reaches TIMEOUT-1: go to ERR.
  - Otherwise: increment the counter.
- RESP: m_ready=1 and m_rdata=captured data. s_valid is all zero. Go to IDLE.
- ERR: m_ready=1, m_rdata=ERR_DATA and bus_err=1. Capture err_addr<=m_addr. No slave sees the write. Go to IDLE.
- s_ready bits for unselected slaves, and any s_ready outside WAIT, are ignored.
- Timeout counter width is $clog2(TIMEOUT). It saturates and never wraps within a transaction.

## Timing
- Reset values:
  - state=IDLE; m_ready=0; s_valid=0; bus_err=0.
  - m_rdata=0; err_addr=0; rdata register=0; counter=0.
- Reset asserted in any state returns to IDLE on the next edge. No pending response is issued.
- s_addr, s_wdata and s_wstrb pass through combinationally from m_*. The master holds them stable until m_ready.
- Hit latency: if m_valid rises at cycle 0, s_valid rises at cycle 1. If s_ready is first seen at cycle k≥1, m_ready pulses at cycle k+1.
  - For the timer, which asserts ready on its second valid cycle, m_ready comes at cycle 3.
- Miss latency: m_ready and bus_err pulse at cycle 1.
- Timeout: with s_ready never asserted, s_valid is high for cycles 1..TIMEOUT. ERR, with m_ready and bus_err, follows at cycle TIMEOUT+1.
- s_ready in the last WAIT cycle takes priority over timeout, giving a normal response.
- m_ready is high for exactly one cycle per accepted request. The master must drop or replace the request in the following cycle.
- A new request in the cycle after m_ready (back-to-back) is decoded normally from IDLE. Minimum throughput is one request per 3 cycles.

## Test plan
- Read at 0x1000_0000 with the timer on slot 0:
  - s_valid[0] is high for cycles 1–2.
  - m_ready pulses at cycle 3 with m_rdata equal to the timer count low word.
  - bus_err stays 0.
- Write 0x1234_5678 with wstrb=4'hF to 0x1000_2004, where slot 2 is ready immediately:
  - s_valid=4'b0100 at cycle 1, with s_wdata and s_wstrb forwarded.
  - m_ready at cycle 2.
  - No other s_valid bit toggles.
- Access to 0x2000_0000 (unmapped):
  - m_ready, bus_err=1 and m_rdata=0xDEAD_BEEF at cycle 1.
  - err_addr=0x2000_0000.
  - s_valid is never asserted.
- Slot 1 with s_ready tied low and TIMEOUT=16:
  - s_valid[1] is high for exactly 16 cycles.
  - Error response at cycle 17.
  - A variant asserting s_ready on cycle 16 gives a normal response at cycle 17.
- Overlapping windows, with slot 0 and slot 3 both matching 0x1000_0000: only s_valid[0] asserts.
- Reset and abort:
  - Asserting reset in WAIT clears s_valid on the next edge, with no m_ready.
  - Separately, dropping m_valid in WAIT returns to IDLE, s_valid drops and no m_ready is issued.

Source files
------------

// File: rtl/bus_decoder.sv
// Single-master to multi-slave bus decoder with base/mask windows,
// registered read data and error termination for misses and hung slaves.
module bus_decoder #(
   parameter int                 NSLV     = 4,
   parameter logic [32*NSLV-1:0] SLV_BASE = {32'h1000_3000, 32'h1000_2000,
                                             32'h1000_1000, 32'h1000_0000},
   parameter logic [32*NSLV-1:0] SLV_MASK = {4{32'hFFFF_F000}},
   parameter int                 TIMEOUT  = 16,
   parameter logic [31:0]        ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m_valid,
   output logic              m_ready,
   input  logic [31:0]       m_addr,
   input  logic [31:0]       m_wdata,
   input  logic [3:0]        m_wstrb,
   output logic [31:0]       m_rdata,
   output logic [NSLV-1:0]   s_valid,
   input  logic [NSLV-1:0]   s_ready,
   output logic [31:0]       s_addr,
   output logic [31:0]       s_wdata,
   output logic [3:0]        s_wstrb,
   input  logic [32*NSLV-1:0] s_rdata,
   output logic              bus_err,
   output logic [31:0]       err_addr
);

   localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP,
      S_ERR
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [IW-1:0]  sel_q;
   logic [CW-1:0]  cnt_q;
   logic [31:0]    rdata_q;
   logic           hit;
   logic [IW-1:0]  hit_idx;
   logic           sel_ready;
   logic [31:0]    sel_rdata;

   assign s_addr  = m_addr;
   assign s_wdata = m_wdata;
   assign s_wstrb = m_wstrb;

   // Scan downwards so the lowest matching window wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (sel_q == IW'(i)) begin
            sel_ready = s_ready[i];
            sel_rdata = s_rdata[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (m_valid) begin
               state_d = hit ? S_WAIT : S_ERR;
            end
         end
         S_WAIT: begin
            if (!m_valid) begin
               state_d = S_IDLE;
            end else if (sel_ready) begin
               state_d = S_RESP;
            end else if (cnt_q == CNT_MAX) begin
               state_d = S_ERR;
            end
         end
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      s_valid = '0;
      m_ready = 1'b0;
      bus_err = 1'b0;
      m_rdata = '0;
      unique case (state_q)
         S_WAIT: begin
            for (int i = 0; i < NSLV; i++) begin
               s_valid[i] = (sel_q == IW'(i));
            end
         end
         S_RESP: begin
            m_ready = 1'b1;
            m_rdata = rdata_q;
         end
         S_ERR: begin
            m_ready = 1'b1;
            bus_err = 1'b1;
            m_rdata = ERR_DATA;
         end
         default: ;
      endcase
   end

   // The counter saturates; WAIT leaves on CNT_MAX so it never wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q    <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         err_addr <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (m_valid && hit) begin
                  sel_q <= hit_idx;
               end
               cnt_q <= '0;
            end
            S_WAIT: begin
               if (m_valid && sel_ready) begin
                  rdata_q <= sel_rdata;
               end else if (m_valid && cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_ERR:   err_addr <= m_addr;
            default: ;
         endcase
      end
   end

endmodule
